// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss-refill path.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } refill_state_t;

   localparam int WORD_BYTES = 4;

   // Clears the offset-within-line bits; line_words must be a power of two.
   function automatic logic [63:0] line_base(input logic [63:0] addr, input int line_words);
      return addr & ~(64'(line_words * WORD_BYTES) - 64'd1);
   endfunction

endpackage

// File: rtl/cache_refill_timer.sv
// Response watchdog for the refill controller: counts WAIT cycles, flags TIMEOUT-1.
module refill_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic timeout
);
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign timeout = (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss refill controller: fetches an aligned cache line one word at a time and
// streams each returned word into the cache as a fill write.
//
//   state | meaning
//   IDLE  | ready for a miss (held off for the cycle fill_done is high)
//   REQ   | word request presented, waiting for mem_req_ready
//   WAIT  | request accepted, waiting for the response or the watchdog
//   DONE  | last fill_valid cycle; fill_done follows next cycle
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_valid,
   input  logic [ADDR_W-1:0] miss_addr,
   output logic              miss_ready,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              fill_valid,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_done,
   output logic              refill_err
);
   localparam int CW = $clog2(LINE_WORDS);
   localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

   refill_state_t     state, state_d;
   logic [ADDR_W-1:0] base;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] word_addr;
   logic              accept, rsp_hit, abort;
   logic              tmr_clr, tmr_en, tmr_to;

   assign word_addr     = base + ADDR_W'(cnt) * ADDR_W'(WORD_BYTES);
   // Gating on fill_done keeps one idle cycle between line completion and the next accept.
   assign miss_ready    = (state == IDLE) && !fill_done;
   assign mem_req_valid = (state == REQ);
   assign mem_req_addr  = mem_req_valid ? word_addr : '0;

   refill_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .timeout (tmr_to)
   );

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      rsp_hit = 1'b0;
      abort   = 1'b0;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      case (state)
         IDLE: begin
            if (miss_valid && !fill_done) begin
               accept  = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               tmr_clr = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            tmr_en = 1'b1;
            // A response in the watchdog's final cycle still wins over the abort.
            if (mem_rsp_valid) begin
               rsp_hit = 1'b1;
               state_d = (cnt == LAST) ? DONE : REQ;
            end else if (tmr_to) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base       <= '0;
         cnt        <= '0;
         fill_valid <= 1'b0;
         fill_addr  <= '0;
         fill_data  <= '0;
         fill_done  <= 1'b0;
         refill_err <= 1'b0;
      end else begin
         fill_valid <= rsp_hit;
         fill_done  <= (state == DONE);
         refill_err <= abort;
         if (accept) begin
            base <= ADDR_W'(line_base(64'(miss_addr), LINE_WORDS));
            cnt  <= '0;
         end
         if (rsp_hit) begin
            fill_addr <= word_addr;
            fill_data <= mem_rsp_data;
            cnt       <= cnt + 1'b1;
         end
      end
   end

endmodule
